// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Brief    : Fetch stage (PC, ROM address, instruction register, branch/halt)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter logic [7:0] HALT_OP = 8'b10001000,
  parameter int         CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [7:0]       start_addr_i,
  output logic [7:0]       rom_addr_o,
  input  logic [7:0]       rom_data_i,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic             branch_back_i,
  input  logic [7:0]       branch_off_i,
  output logic [7:0]       instr_o,
  output logic [7:0]       instr_pc_o,
  output logic             instr_valid_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_pc, w_pc_nxt;
  logic [7:0]       r_instr, w_instr_nxt;
  logic [7:0]       r_instr_pc, w_instr_pc_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_halted, w_halted_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       w_base;
  logic [7:0]       w_target;

  // Branch distance is relative to the byte after the branch instruction.
  assign w_base   = r_instr_pc + 8'd1;
  assign w_target = branch_back_i ? (w_base - branch_off_i) : (w_base + branch_off_i);

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    w_halted_nxt   = r_halted;
    w_cnt_nxt      = r_cnt;
    if (!stall_i) begin
      case (r_state)
        S_IDLE, S_HALT: begin
          w_valid_nxt = 1'b0;
          if (start_i) begin
            w_pc_nxt     = start_addr_i;
            w_cnt_nxt    = '0;
            w_halted_nxt = 1'b0;
            w_state_nxt  = S_RUN;
          end
        end
        S_RUN: begin
          if (branch_taken_i && r_valid) begin
            w_pc_nxt    = w_target;
            w_valid_nxt = 1'b0;
          end else begin
            w_instr_nxt    = rom_data_i;
            w_instr_pc_nxt = r_pc;
            w_valid_nxt    = 1'b1;
            if (r_cnt != c_cnt_max) w_cnt_nxt = r_cnt + c_cnt_one;
            // A halt byte parks the PC on its own address.
            if (rom_data_i == HALT_OP) begin
              w_state_nxt  = S_HALT;
              w_halted_nxt = 1'b1;
            end else begin
              w_pc_nxt = r_pc + 8'd1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_halted   <= w_halted_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign rom_addr_o    = r_pc;
  assign instr_o       = r_instr;
  assign instr_pc_o    = r_instr_pc;
  assign instr_valid_o = r_valid;
  assign halted_o      = r_halted;
  assign instr_cnt_o   = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Self-checking bench for instr_fetch (directed + randomized)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  localparam int TB_CNT_W = 4;

  logic                clk;
  logic                reset;
  logic                start;
  logic [7:0]          start_addr;
  logic [7:0]          rom_addr;
  logic [7:0]          rom_data;
  logic                stall;
  logic                branch_taken;
  logic                branch_back;
  logic [7:0]          branch_off;
  logic [7:0]          instr;
  logic [7:0]          instr_pc;
  logic                valid;
  logic                halted;
  logic [TB_CNT_W-1:0] cnt;

  logic [7:0] rom [256];
  int n_cmp = 0;
  int n_err = 0;

  // Behavioural reference state
  int m_pc, m_instr, m_ipc, m_cnt;
  bit m_valid, m_halted, m_running;

  assign rom_data = rom[rom_addr];

  instr_fetch #(.HALT_OP(8'h88), .CNT_W(TB_CNT_W)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .start_addr_i(start_addr),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data), .stall_i(stall),
    .branch_taken_i(branch_taken), .branch_back_i(branch_back),
    .branch_off_i(branch_off), .instr_o(instr), .instr_pc_o(instr_pc),
    .instr_valid_o(valid), .halted_o(halted), .instr_cnt_o(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 256; i++) rom[i] = 8'(i);
    rom[136] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_back = 1'b0; branch_off = 8'd0; start_addr = 8'd0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic start_at(input logic [7:0] a);
    start = 1'b1; start_addr = a;
    tick();
    start = 1'b0;
  endtask

  // Spec-level step: applies one clock edge worth of rules to the model.
  task automatic model_step();
    int b;
    if (reset) begin
      m_pc = 0; m_instr = 0; m_ipc = 0; m_cnt = 0;
      m_valid = 0; m_halted = 0; m_running = 0;
    end else if (!stall) begin
      if (!m_running) begin
        m_valid = 0;
        if (start) begin
          m_pc = int'(start_addr); m_cnt = 0; m_halted = 0; m_running = 1;
        end
      end else if (branch_taken && m_valid) begin
        if (branch_back) m_pc = (m_ipc + 1 - int'(branch_off) + 256) % 256;
        else             m_pc = (m_ipc + 1 + int'(branch_off)) % 256;
        m_valid = 0;
      end else begin
        b = int'(rom[m_pc]);
        m_instr = b; m_ipc = m_pc; m_valid = 1;
        if (m_cnt < (1 << TB_CNT_W) - 1) m_cnt = m_cnt + 1;
        if (b == 'h88) begin m_running = 0; m_halted = 1; end
        else m_pc = (m_pc + 1) % 256;
      end
    end
  endtask

  task automatic test_reset();
    start = 1'b1; start_addr = 8'd77; stall = 1'b0; branch_taken = 1'b1;
    reset = 1'b1;
    tick(); tick();
    n_cmp++; if (instr !== 8'd0) begin n_err++; $display("FAIL reset_instr: got %h want 00", instr); end
    n_cmp++; if (instr_pc !== 8'd0) begin n_err++; $display("FAIL reset_ipc: got %h want 00", instr_pc); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_cmp++; if (cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    n_cmp++; if (rom_addr !== 8'd0) begin n_err++; $display("FAIL reset_addr: got %h want 00", rom_addr); end
    reset = 1'b0; start = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[1] = 8'hC1; rom[2] = 8'h90;
    do_reset();
    start_at(8'd1);
    n_cmp++; if (rom_addr !== 8'd1) begin n_err++; $display("FAIL seq_addr: got %0d want 1", rom_addr); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL seq_bubble: got %b want 0", valid); end
    tick();
    n_cmp++; if (instr !== 8'hC1 || instr_pc !== 8'd1 || valid !== 1'b1)
      begin n_err++; $display("FAIL seq_first: got %h@%0d v%b want c1@1 v1", instr, instr_pc, valid); end
    tick();
    n_cmp++; if (instr !== 8'h90 || instr_pc !== 8'd2 || valid !== 1'b1)
      begin n_err++; $display("FAIL seq_second: got %h@%0d v%b want 90@2 v1", instr, instr_pc, valid); end
    n_cmp++; if (cnt !== 4'd2) begin n_err++; $display("FAIL seq_cnt: got %0d want 2", cnt); end
  endtask

  task automatic test_branch(input logic [7:0] spc, input logic [7:0] off,
                             input logic back, input logic [7:0] tgt);
    fill_linear();
    do_reset();
    start_at(spc);
    tick();
    branch_taken = 1'b1; branch_back = back; branch_off = off;
    tick();
    branch_taken = 1'b0;
    n_cmp++; if (valid !== 1'b0 || instr_pc !== spc)
      begin n_err++; $display("FAIL br_bubble: got v%b ipc %0d want v0 ipc %0d", valid, instr_pc, spc); end
    n_cmp++; if (rom_addr !== tgt) begin n_err++; $display("FAIL br_addr: got %0d want %0d", rom_addr, tgt); end
    tick();
    n_cmp++; if (instr_pc !== tgt || valid !== 1'b1 || instr !== tgt)
      begin n_err++; $display("FAIL br_target: got %h@%0d v%b want %h@%0d v1", instr, instr_pc, valid, tgt, tgt); end
    n_cmp++; if (cnt !== 4'd2) begin n_err++; $display("FAIL br_cnt: got %0d want 2", cnt); end
  endtask

  task automatic test_halt_restart();
    fill_linear();
    rom[93] = 8'h88;
    do_reset();
    start_at(8'd92);
    tick(); tick();
    n_cmp++; if (instr !== 8'h88 || instr_pc !== 8'd93 || valid !== 1'b1 || halted !== 1'b1)
      begin n_err++; $display("FAIL halt_latch: got %h@%0d v%b h%b want 88@93 v1 h1", instr, instr_pc, valid, halted); end
    n_cmp++; if (rom_addr !== 8'd93) begin n_err++; $display("FAIL halt_addr: got %0d want 93", rom_addr); end
    tick();
    n_cmp++; if (valid !== 1'b0 || halted !== 1'b1)
      begin n_err++; $display("FAIL halt_once: got v%b h%b want v0 h1", valid, halted); end
    tick();
    n_cmp++; if (rom_addr !== 8'd93 || valid !== 1'b0)
      begin n_err++; $display("FAIL halt_hold: got addr %0d v%b want 93 v0", rom_addr, valid); end
    start_at(8'd94);
    n_cmp++; if (halted !== 1'b0 || rom_addr !== 8'd94 || cnt !== 4'd0)
      begin n_err++; $display("FAIL restart: got h%b addr %0d cnt %0d want h0 94 0", halted, rom_addr, cnt); end
    tick();
    n_cmp++; if (instr_pc !== 8'd94 || valid !== 1'b1 || instr !== 8'd94)
      begin n_err++; $display("FAIL restart_fetch: got %h@%0d v%b want 5e@94 v1", instr, instr_pc, valid); end
  endtask

  task automatic test_stall();
    fill_linear();
    do_reset();
    start_at(8'd40);
    tick(); tick(); tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      branch_taken = (k == 1); branch_back = 1'b0; branch_off = 8'd50;
      tick();
      n_cmp++; if (instr !== 8'd42 || instr_pc !== 8'd42 || valid !== 1'b1 || cnt !== 4'd3 || rom_addr !== 8'd43)
        begin n_err++; $display("FAIL stall_hold%0d: got %h@%0d v%b cnt %0d addr %0d want 2a@42 v1 cnt 3 addr 43",
                                k, instr, instr_pc, valid, cnt, rom_addr); end
    end
    stall = 1'b0; branch_taken = 1'b0;
    tick();
    n_cmp++; if (instr_pc !== 8'd43 || valid !== 1'b1 || cnt !== 4'd4)
      begin n_err++; $display("FAIL stall_resume: got ipc %0d v%b cnt %0d want 43 v1 4", instr_pc, valid, cnt); end
  endtask

  task automatic test_branch_beats_halt();
    fill_linear();
    rom[61] = 8'h88;
    do_reset();
    start_at(8'd60);
    tick();
    branch_taken = 1'b1; branch_back = 1'b0; branch_off = 8'd3;
    tick();
    branch_taken = 1'b0;
    n_cmp++; if (valid !== 1'b0 || halted !== 1'b0 || rom_addr !== 8'd64)
      begin n_err++; $display("FAIL br_vs_halt: got v%b h%b addr %0d want v0 h0 64", valid, halted, rom_addr); end
    tick();
    n_cmp++; if (instr_pc !== 8'd64 || valid !== 1'b1)
      begin n_err++; $display("FAIL br_vs_halt_tgt: got ipc %0d v%b want 64 v1", instr_pc, valid); end
  endtask

  task automatic test_reset_while_stalled();
    fill_linear();
    do_reset();
    start_at(8'd10);
    tick(); tick();
    stall = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (instr !== 8'd0 || instr_pc !== 8'd0 || valid !== 1'b0 || halted !== 1'b0 || cnt !== '0 || rom_addr !== 8'd0)
      begin n_err++; $display("FAIL rst_stall: got %h@%0d v%b h%b cnt %0d addr %0d want all zero",
                              instr, instr_pc, valid, halted, cnt, rom_addr); end
    stall = 1'b0;
    tick(); tick();
    n_cmp++; if (valid !== 1'b0 || rom_addr !== 8'd0)
      begin n_err++; $display("FAIL rst_idle: got v%b addr %0d want v0 addr 0", valid, rom_addr); end
  endtask

  task automatic test_wrap_and_saturation();
    fill_linear();
    do_reset();
    start_at(8'd254);
    tick(); tick();
    n_cmp++; if (instr_pc !== 8'd255 || rom_addr !== 8'd0)
      begin n_err++; $display("FAIL wrap_addr: got ipc %0d addr %0d want 255 0", instr_pc, rom_addr); end
    tick();
    n_cmp++; if (instr_pc !== 8'd0 || instr !== 8'd0 || valid !== 1'b1)
      begin n_err++; $display("FAIL wrap_fetch: got %h@%0d v%b want 00@0 v1", instr, instr_pc, valid); end
    repeat (11) tick();
    n_cmp++; if (cnt !== 4'd14) begin n_err++; $display("FAIL cnt_14: got %0d want 14", cnt); end
    repeat (6) tick();
    n_cmp++; if (cnt !== 4'd15) begin n_err++; $display("FAIL cnt_sat: got %0d want 15", cnt); end
  endtask

  task automatic test_random();
    int r;
    logic [7:0] entries [3];
    entries[0] = 8'd1; entries[1] = 8'd94; entries[2] = 8'd139;
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 15);
      rom[i] = (r == 0) ? 8'h88 : 8'($urandom);
    end
    reset = 1'b1; stall = 1'b0; start = 1'b0; branch_taken = 1'b0;
    model_step();
    tick();
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 249) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      start        = ($urandom_range(0, 11) == 0);
      start_addr   = ($urandom_range(0, 1) == 0) ? entries[$urandom_range(0, 2)] : 8'($urandom);
      branch_taken = ($urandom_range(0, 5) == 0);
      branch_back  = 1'($urandom);
      branch_off   = 8'($urandom);
      model_step();
      tick();
      n_cmp++;
      if (int'(rom_addr) != m_pc || int'(instr) != m_instr || int'(instr_pc) != m_ipc ||
          valid !== m_valid || halted !== m_halted || int'(cnt) != m_cnt) begin
        n_err++;
        $display("FAIL rand_cyc%0d: got addr %0d %h@%0d v%b h%b cnt %0d want addr %0d %h@%0d v%b h%b cnt %0d",
                 c, rom_addr, instr, instr_pc, valid, halted, cnt,
                 m_pc, m_instr, m_ipc, m_valid, m_halted, m_cnt);
      end
    end
    reset = 1'b0; stall = 1'b0; start = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_addr = 8'd0; stall = 1'b0;
    branch_taken = 1'b0; branch_back = 1'b0; branch_off = 8'd0;
    fill_linear();
    test_reset();
    test_sequential();
    test_branch(8'd18, 8'd6, 1'b0, 8'd25);
    test_branch(8'd127, 8'd25, 1'b1, 8'd103);
    test_branch(8'd2, 8'd10, 1'b1, 8'd249);
    test_halt_restart();
    test_stall();
    test_branch_beats_halt();
    test_reset_while_stalled();
    test_wrap_and_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
